// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - shared VGA timing constants, coordinate type and region decode
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        ACTIVE      = 2'd0,
        FRONT_PORCH = 2'd1,
        SYNC        = 2'd2,
        BACK_PORCH  = 2'd3
    } axis_region_t;

    // Regions are laid out in order: active, front porch, sync, back porch.
    function automatic axis_region_t region_of(input coord_t c, input int act_len,
                                               input int fp_len, input int sync_len);
        int ci;
        ci = int'(c);
        if (ci < act_len)
            return ACTIVE;
        else if (ci < act_len + fp_len)
            return FRONT_PORCH;
        else if (ci < act_len + fp_len + sync_len)
            return SYNC;
        return BACK_PORCH;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle from the timing generator to the painter
interface vga_timing_if;
    import vga_pkg::*;

    logic   hsync;
    logic   vsync;
    logic   vidOn;
    coord_t x;
    coord_t y;
    logic   pix_ce;
    logic   frame_start;
    logic   line_end;

    modport master (
        output hsync, vsync, vidOn, x, y, pix_ce, frame_start, line_end
    );

    modport slave (
        input hsync, vsync, vidOn, x, y, pix_ce, frame_start, line_end
    );

endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping counter with registered active/sync flags
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE_LEN = 640,
    parameter int FP_LEN     = 16,
    parameter int SYNC_LEN   = 96,
    parameter int BP_LEN     = 48
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   step,
    output coord_t count,
    output logic   wrap,
    output logic   active,
    output logic   sync_window
);

    localparam int     TOTAL = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;
    localparam coord_t LAST  = coord_t'(TOTAL - 1);

    coord_t       count_nxt;
    axis_region_t region_nxt;

    // Flags are decoded from the next count so they land on the same edge as the count.
    always_comb begin
        wrap      = step && (count == LAST);
        count_nxt = count;
        if (wrap)
            count_nxt = '0;
        else if (step)
            count_nxt = count + 10'd1;
        region_nxt = region_of(count_nxt, ACTIVE_LEN, FP_LEN, SYNC_LEN);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count       <= '0;
            active      <= 1'b0;
            sync_window <= 1'b0;
        end else begin
            count       <= count_nxt;
            active      <= (region_nxt == ACTIVE);
            sync_window <= (region_nxt == SYNC);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 raster timing generator; VGA_PIXDIV2_EN selects a 50 MHz clock with /2 pixel enable
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    vga_timing_if.master vga
);

    localparam int     H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int     V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end

    logic   run_q;
    logic   pix_ce_q;
    logic   step;
    logic   frame_start_q;
    coord_t h_count, v_count;
    logic   h_wrap, v_wrap;
    logic   h_active, v_active;
    logic   h_sync, v_sync;

    // run_q low means (0,0) has not been presented yet; the first edge out of reset
    // presents it without stepping.
    always_ff @(posedge clk) begin
        if (!reset_n)
            run_q <= 1'b0;
        else
            run_q <= 1'b1;
    end

`ifdef VGA_PIXDIV2_EN
    // pix_ce is high on the first cycle of each pixel; the step edge is the one that raises it.
    always_ff @(posedge clk) begin
        if (!reset_n)
            pix_ce_q <= 1'b0;
        else
            pix_ce_q <= ~pix_ce_q;
    end
    assign step = run_q && !pix_ce_q;
`else
    assign pix_ce_q = 1'b1;
    assign step     = run_q;
`endif

    vga_axis_counter #(
        .ACTIVE_LEN (H_ACTIVE),
        .FP_LEN     (H_FP),
        .SYNC_LEN   (H_SYNC),
        .BP_LEN     (H_BP)
    ) u_h_axis (
        .clk         (clk),
        .reset_n     (reset_n),
        .step        (step),
        .count       (h_count),
        .wrap        (h_wrap),
        .active      (h_active),
        .sync_window (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE_LEN (V_ACTIVE),
        .FP_LEN     (V_FP),
        .SYNC_LEN   (V_SYNC),
        .BP_LEN     (V_BP)
    ) u_v_axis (
        .clk         (clk),
        .reset_n     (reset_n),
        .step        (h_wrap),
        .count       (v_count),
        .wrap        (v_wrap),
        .active      (v_active),
        .sync_window (v_sync)
    );

    always_ff @(posedge clk) begin
        if (!reset_n)
            frame_start_q <= 1'b0;
        else
            frame_start_q <= !run_q || v_wrap;
    end

    assign vga.x           = h_count;
    assign vga.y           = v_count;
    assign vga.pix_ce      = pix_ce_q;
    assign vga.vidOn       = h_active && v_active;
    assign vga.hsync       = h_sync ? SYNC_POL : ~SYNC_POL;
    assign vga.vsync       = v_sync ? SYNC_POL : ~SYNC_POL;
    assign vga.frame_start = frame_start_q;
    assign vga.line_end    = (h_count == H_LAST);

endmodule
